// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding, parity modes and oversampling constants for the UART receiver
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam int OSR        = 16;
    localparam int SAMPLE_LO  = 7;
    localparam int SAMPLE_MID = 8;
    localparam int SAMPLE_HI  = 9;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered head, valid and level; pushes while full are dropped
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         s_tdata,
    input  logic                     s_tvalid,
    output logic                     overflow,
    output logic [WIDTH-1:0]         m_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_next;
    logic [AW:0]      level_next;
    logic             full;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full       = (level == (AW+1)'(DEPTH));
        do_pop     = m_tvalid & m_tready;
        do_push    = s_tvalid & (~full | do_pop);
        overflow   = s_tvalid & full & ~do_pop;
        rd_next    = rd_ptr + AW'(do_pop);
        level_next = level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= s_tdata;
        end
    end

    // The head register bypasses the array when the new head is the word being written now.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
        end else begin
            wr_ptr   <= wr_ptr + AW'(do_push);
            rd_ptr   <= rd_next;
            level    <= level_next;
            m_tvalid <= (level_next != '0);
            if (level_next != '0) begin
                m_tdata <= (do_push && (wr_ptr == rd_next)) ? s_tdata : mem[rd_next];
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 16x oversampled UART receiver with parity/framing/break flags feeding a receive FIFO
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          uart_rxd,
    input  logic                          uart_rx_en,
    output logic [PAYLOAD_BITS-1:0]       rx_data,
    output logic                          rx_parity_err,
    output logic                          rx_frame_err,
    output logic                          rx_break,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          rx_overrun,
    input  logic                          rx_overrun_clr,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    output logic                          rx_busy
);

    localparam int DIV   = CLK_HZ / (BIT_RATE * OSR);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int FW    = PAYLOAD_BITS + 3;

    rx_state_t               state_q, state_d;
    logic                    rxd_meta, rxd_sync, rxd_prev, rxd_fall;
    logic [DIV_W-1:0]        div_cnt;
    logic                    tick;
    logic [3:0]              tick_idx;
    logic                    samp_lo, samp_mid;
    logic                    bit_val, at_mid, at_end;
    logic [3:0]              bit_idx;
    logic [1:0]              stop_idx;
    logic                    last_data, last_stop;
    logic [PAYLOAD_BITS-1:0] shift_q;
    logic                    par_q, ferr_q;
    logic                    par_calc, perr_now, ferr_now, brk_now;
    logic                    start_det, frame_done;
    logic                    push_q;
    logic [FW-1:0]           push_data_q;
    logic [FW-1:0]           fifo_tdata;
    logic                    fifo_overflow;

    always_comb begin
        rxd_fall  = rxd_prev & ~rxd_sync;
        tick      = (div_cnt == DIV_W'(DIV - 1));
        at_mid    = tick && (tick_idx == 4'(SAMPLE_HI));
        at_end    = tick && (tick_idx == 4'(OSR - 1));
        bit_val   = maj3(samp_lo, samp_mid, rxd_sync);
        last_data = (bit_idx == 4'(PAYLOAD_BITS - 1));
        last_stop = (stop_idx == 2'(STOP_BITS - 1));
        par_calc  = (^shift_q) ^ par_q;
        if (PARITY == PARITY_EVEN) begin
            perr_now = par_calc;
        end else if (PARITY == PARITY_ODD) begin
            perr_now = ~par_calc;
        end else begin
            perr_now = 1'b0;
        end
        ferr_now  = ferr_q | ~bit_val;
        brk_now   = (shift_q == '0) & ferr_now;
        rx_busy   = (state_q != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        start_det  = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (uart_rx_en && rxd_fall) begin
                    state_d   = ST_START;
                    start_det = 1'b1;
                end
            end
            ST_START: begin
                if (at_mid && bit_val) begin
                    state_d = ST_IDLE;
                end else if (at_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (at_end && last_data) begin
                    state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (at_end) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                // The last stop bit is accepted at its centre so back-to-back frames are not missed.
                if (at_mid && last_stop) begin
                    state_d    = ST_IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxd_meta    <= 1'b1;
            rxd_sync    <= 1'b1;
            rxd_prev    <= 1'b1;
            div_cnt     <= '0;
            tick_idx    <= '0;
            samp_lo     <= 1'b1;
            samp_mid    <= 1'b1;
            bit_idx     <= '0;
            stop_idx    <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            ferr_q      <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
        end else begin
            rxd_meta <= uart_rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;

            if (start_det || tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end

            if (start_det) begin
                tick_idx <= '0;
            end else if (tick) begin
                tick_idx <= tick_idx + 4'd1;
            end

            if (tick && (tick_idx == 4'(SAMPLE_LO))) samp_lo  <= rxd_sync;
            if (tick && (tick_idx == 4'(SAMPLE_MID))) samp_mid <= rxd_sync;

            if (start_det) begin
                bit_idx  <= '0;
                stop_idx <= '0;
                ferr_q   <= 1'b0;
            end else begin
                if (state_q == ST_DATA && at_end) bit_idx <= bit_idx + 4'd1;
                if (state_q == ST_STOP && at_end) stop_idx <= stop_idx + 2'd1;
                if (state_q == ST_STOP && at_mid && !bit_val) ferr_q <= 1'b1;
            end

            // LSB arrives first, so shifting in from the top leaves bit 0 in place after the last bit.
            if (state_q == ST_DATA && at_mid) shift_q <= {bit_val, shift_q[PAYLOAD_BITS-1:1]};
            if (state_q == ST_PARITY && at_mid) par_q <= bit_val;

            push_q <= frame_done;
            if (frame_done) push_data_q <= {brk_now, ferr_now, perr_now, shift_q};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_overrun <= 1'b0;
        end else if (fifo_overflow) begin
            rx_overrun <= 1'b1;
        end else if (rx_overrun_clr) begin
            rx_overrun <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .s_tdata  (push_data_q),
        .s_tvalid (push_q),
        .overflow (fifo_overflow),
        .m_tdata  (fifo_tdata),
        .m_tvalid (rx_valid),
        .m_tready (rx_ready),
        .level    (rx_level)
    );

    assign {rx_break, rx_frame_err, rx_parity_err, rx_data} = fifo_tdata;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo against a frame-level queue model
module tb_uart_rx_fifo;

    localparam int CLK_HZ   = 1_600_000;
    localparam int BIT_RATE = 10_000;
    localparam int DIV      = 10;
    localparam int BIT_CLKS = CLK_HZ / BIT_RATE;
    localparam int DEPTH    = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, en;
    logic       rxd0, rxd1, rdy0, rdy1, clr0, clr1;
    logic [7:0] dat0, dat1;
    logic       perr0, perr1, ferr0, ferr1, brk0, brk1;
    logic       valid0, valid1, ovr0, ovr1, busy0, busy1;
    logic [3:0] lvl0, lvl1;

    uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .PAYLOAD_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .uart_rxd(rxd0), .uart_rx_en(en),
        .rx_data(dat0), .rx_parity_err(perr0), .rx_frame_err(ferr0), .rx_break(brk0),
        .rx_valid(valid0), .rx_ready(rdy0), .rx_overrun(ovr0), .rx_overrun_clr(clr0),
        .rx_level(lvl0), .rx_busy(busy0)
    );

    uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .PAYLOAD_BITS(8), .PARITY(1),
                   .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_p (
        .clk(clk), .reset(reset), .uart_rxd(rxd1), .uart_rx_en(en),
        .rx_data(dat1), .rx_parity_err(perr1), .rx_frame_err(ferr1), .rx_break(brk1),
        .rx_valid(valid1), .rx_ready(rdy1), .rx_overrun(ovr1), .rx_overrun_clr(clr1),
        .rx_level(lvl1), .rx_busy(busy1)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [10:0] q0[$];
    logic [10:0] q1[$];
    logic        ov0 = 1'b0;
    logic        ov1 = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] head_of(input int line);
        return (line == 0) ? {brk0, ferr0, perr0, dat0} : {brk1, ferr1, perr1, dat1};
    endfunction

    task automatic send_bit(input int line, input logic b);
        @(negedge clk);
        if (line == 0) rxd0 = b; else rxd1 = b;
        repeat (BIT_CLKS - 1) @(negedge clk);
    endtask

    task automatic send_frame(input int line, input logic [7:0] d, input logic pbit, input logic stop);
        logic        perr, ferr, brk;
        logic [10:0] entry;
        send_bit(line, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(line, d[i]);
        if (line == 1) send_bit(line, pbit);
        send_bit(line, stop);
        send_bit(line, 1'b1);
        perr  = (line == 1) ? ((^d) ^ pbit) : 1'b0;
        ferr  = ~stop;
        brk   = (d == 8'h00) && ferr;
        entry = {brk, ferr, perr, d};
        if (line == 0) begin
            if (q0.size() == DEPTH) ov0 = 1'b1; else q0.push_back(entry);
        end else begin
            if (q1.size() == DEPTH) ov1 = 1'b1; else q1.push_back(entry);
        end
    endtask

    task automatic pop(input int line);
        @(negedge clk);
        if (line == 0) rdy0 = 1'b1; else rdy1 = 1'b1;
        @(negedge clk);
        rdy0 = 1'b0;
        rdy1 = 1'b0;
        if (line == 0 && q0.size() > 0) void'(q0.pop_front());
        if (line == 1 && q1.size() > 0) void'(q1.pop_front());
    endtask

    task automatic check_state(input int line, input string tag);
        int          sz;
        logic [10:0] exp_head;
        sz       = (line == 0) ? q0.size() : q1.size();
        exp_head = '0;
        if (sz > 0) exp_head = (line == 0) ? q0[0] : q1[0];
        check({tag, "_level"}, (line == 0) ? lvl0 : lvl1, sz);
        check({tag, "_valid"}, (line == 0) ? valid0 : valid1, (sz != 0));
        check({tag, "_overrun"}, (line == 0) ? ovr0 : ovr1, (line == 0) ? ov0 : ov1);
        if (sz > 0) check({tag, "_head"}, head_of(line), exp_head);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; en = 1'b1;
        rxd0 = 1'b1; rxd1 = 1'b1; rdy0 = 1'b0; rdy1 = 1'b0; clr0 = 1'b0; clr1 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", valid0, 0);
        check("rst_level", lvl0, 0);
        check("rst_data", dat0, 0);
        check("rst_flags", {brk0, ferr0, perr0}, 0);
        check("rst_overrun", ovr0, 0);
        check("rst_busy", busy0, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // clean 0x55 frame
        send_frame(0, 8'h55, 1'b0, 1'b1);
        check("f55_data", dat0, 8'h55);
        check("f55_flags", {brk0, ferr0, perr0}, 3'b000);
        check("f55_lvl", lvl0, 1);
        check_state(0, "f55");
        pop(0);
        check_state(0, "f55_pop");

        // zero data with a low stop bit is a framing error and a break
        send_frame(0, 8'h00, 1'b0, 1'b0);
        check("brk_flags", {brk0, ferr0}, 2'b11);
        check_state(0, "brk");
        pop(0);

        // glitch shorter than half a bit is a false start
        @(negedge clk);
        rxd0 = 1'b0;
        repeat (3 * DIV) @(negedge clk);
        check("glitch_busy_hi", busy0, 1);
        rxd0 = 1'b1;
        repeat (BIT_CLKS - 3 * DIV) @(negedge clk);
        check("glitch_busy_lo", busy0, 0);
        check_state(0, "glitch");

        // even parity: 0xA3 has four ones, so parity bit 1 is wrong
        send_frame(1, 8'hA3, 1'b1, 1'b1);
        check("par_bad_data", dat1, 8'hA3);
        check("par_bad_err", perr1, 1);
        check_state(1, "par_bad");
        pop(1);
        send_frame(1, 8'hA3, 1'b0, 1'b1);
        check("par_ok_err", perr1, 0);
        check_state(1, "par_ok");
        pop(1);

        // overflow: nine frames into an eight-entry FIFO with no consumer
        for (int i = 1; i <= 9; i++) send_frame(0, 8'(i), 1'b0, 1'b1);
        check("ovf_level", lvl0, 8);
        check("ovf_flag", ovr0, 1);
        check_state(0, "ovf");
        for (int i = 1; i <= 8; i++) begin
            check("ovf_seq", dat0, i);
            pop(0);
        end
        check_state(0, "ovf_drained");
        pop(0);
        check("empty_pop_level", lvl0, 0);
        @(negedge clk);
        clr0 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0;
        ov0 = 1'b0;
        check("ovf_clr", ovr0, 0);

        // random frames with random stop/parity errors and random consumer pops
        for (int k = 0; k < 12; k++) begin
            int         line;
            logic [7:0] d;
            logic       pbit, stop;
            line = int'($urandom_range(0, 1));
            d    = 8'($urandom);
            pbit = 1'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send_frame(line, d, pbit, stop);
            check_state(line, "rnd");
            if ($urandom_range(0, 1) == 1) begin
                pop(line);
                check_state(line, "rnd_pop");
            end
        end

        // reset in the middle of DATA discards everything
        send_frame(0, 8'h5A, 1'b0, 1'b1);
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        check("mid_busy", busy0, 1);
        @(negedge clk);
        reset = 1'b1;
        rxd0 = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", valid0, 0);
        check("mid_rst_level", lvl0, 0);
        check("mid_rst_data", dat0, 0);
        check("mid_rst_flags", {brk0, ferr0, perr0}, 0);
        check("mid_rst_overrun", ovr0, 0);
        check("mid_rst_busy", busy0, 0);
        check("mid_rst_level_p", lvl1, 0);
        q0.delete(); q1.delete(); ov0 = 1'b0; ov1 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2 * BIT_CLKS) @(negedge clk);
        send_frame(0, 8'hC3, 1'b0, 1'b1);
        check("post_rst_data", dat0, 8'hC3);
        check_state(0, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000: system clock frequency in Hz.
REQ-002 Parameter BIT_RATE, default 9600: line bit rate in bits/s.
REQ-003 Parameter PAYLOAD_BITS, default 8, legal range 5..9: data bits per frame.
REQ-004 Parameter PARITY, default 0: 0 = none, 1 = even, 2 = odd.
REQ-005 Parameter STOP_BITS, default 1, legal range 1..2: stop bits expected per frame.
REQ-006 Parameter FIFO_DEPTH, default 8, power of two and at least 2: receive FIFO entries.
REQ-007 Port list (name, direction, width, meaning):
- clk, in, 1, sole clock; all state on its rising edge.
- reset, in, 1, asynchronous, active-high reset.
- uart_rxd, in, 1, serial line; idle high.
- uart_rx_en, in, 1, receive enable.
- rx_data, out, PAYLOAD_BITS, FIFO head data.
- rx_parity_err, out, 1, head entry parity error.
- rx_frame_err, out, 1, head entry framing error.
- rx_break, out, 1, head entry break.
- rx_valid, out, 1, FIFO non-empty.
- rx_ready, in, 1, consumer pop.
- rx_overrun, out, 1, sticky overflow flag.
- rx_overrun_clr, in, 1, clears rx_overrun.
- rx_level, out, $clog2(FIFO_DEPTH)+1, FIFO occupancy.
- rx_busy, out, 1, FSM not IDLE.

Function
REQ-008 uart_rxd SHALL pass through a 2-flop synchroniser, reset to 1, before any use.
REQ-009 A tick SHALL pulse once every DIV = CLK_HZ/(BIT_RATE*16) clocks (integer division), giving 16 ticks per bit; the tick counter SHALL free-run in IDLE and reload to 0 on start detection.
REQ-010 Each bit SHALL resolve as the majority of the samples at ticks 7, 8 and 9 of that bit.
REQ-011 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-012 IDLE -> START SHALL occur on a synchronised 1->0 transition while uart_rx_en=1; uart_rx_en SHALL be sampled only in IDLE, and deasserting it mid-frame SHALL NOT abort the frame.
REQ-013 In START, a majority-high start bit SHALL be a false start: return to IDLE, no FIFO write. Otherwise go to DATA at the end of tick 15.
REQ-014 DATA SHALL receive PAYLOAD_BITS bits, LSB first, then go to PARITY if PARITY!=0, else to STOP.
REQ-015 Parity error SHALL set when the XOR of data and parity bit is 1 (even) or 0 (odd); it SHALL always be 0 when PARITY=0.
REQ-016 STOP SHALL check STOP_BITS bits; any stop bit resolved low SHALL set frame error. The frame completes at tick 9 of the last stop bit, without waiting the full bit, and the FSM returns to IDLE.
REQ-017 Break SHALL be set when all data bits are 0 and the frame error is set.
REQ-018 On completion, {break, frame_err, parity_err, data} SHALL be pushed to the FIFO in the following clock; rx_valid SHALL assert on the clock after that push.
REQ-019 rx_data and the three flags SHALL always reflect the FIFO head; a pop SHALL occur when rx_valid && rx_ready.
REQ-020 Push while full without a same-cycle pop SHALL drop the new frame, keep FIFO contents, and set rx_overrun. Push while full with a same-cycle pop SHALL be accepted.
REQ-021 rx_ready while empty SHALL be ignored; a simultaneous push and pop while empty SHALL perform the push only.
REQ-022 rx_overrun SHALL clear on rx_overrun_clr; if a set and a clear coincide, set SHALL win.
REQ-023 rx_level SHALL range 0..FIFO_DEPTH and update in the same clock as each push or pop.

Reset
REQ-024 Reset SHALL drive FSM=IDLE and FIFO pointers, rx_level, rx_valid, rx_overrun, rx_busy, rx_data and all flags to 0, with synchroniser flops at 1; reset mid-frame SHALL discard the partial frame.

Structure
REQ-025 A shared package uart_pkg SHALL hold the FSM state encoding, the parity-mode constants (PARITY_NONE/EVEN/ODD) and the oversample constants (OSR=16, sample ticks 7/8/9).
REQ-026 The FIFO SHALL be a separate sub-module, sync_fifo, parametrised by width and depth, with registered outputs.

Verification (bench parameters: CLK_HZ=1_600_000, BIT_RATE=10_000, so DIV=10)
REQ-027 Defaults; send 0x55 with a valid stop -> rx_valid, rx_data=0x55, all flags 0, rx_level=1.
REQ-028 PARITY=1; send 0xA3 with parity bit 1 (wrong) -> rx_data=0xA3, rx_parity_err=1; same frame with parity 0 -> no error.
REQ-029 Send 0x00 with stop bit 0 -> rx_frame_err=1, rx_break=1.
REQ-030 Hold uart_rxd low for 3 ticks, then high -> no FIFO write; rx_busy returns to 0 within 1 bit time.
REQ-031 rx_ready=0; send 9 frames 0x01..0x09 -> rx_level=8, rx_overrun=1, popped sequence 0x01..0x08; rx_overrun_clr clears the flag.
REQ-032 Assert reset in the middle of DATA -> all outputs 0; next frame 0xC3 is received correctly.
